// File: rtl/neuron_sigmoid_mac_pkg.sv
// ============================================================================
//  Module   : neuron_pkg
//  Purpose  : Shared types, PLAN sigmoid constants and fixed-point helpers
//             for neuron_sigmoid_mac.
//  Config   : NEURON_SAT_EN selects saturating narrowing (default: wrap).
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package neuron_pkg;

    // Working width of the helper arithmetic; supports BITS up to 32.
    localparam int FX_W = 64;

    // Controller state encoding
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FP_MAC = 3'd1,
        FP_ACT = 3'd2,
        BP_DZ  = 3'd3,
        BP_G   = 3'd4,
        BP_UPD = 3'd5,
        DONE   = 3'd6
    } state_t;

    // PLAN breakpoints and offsets in units of 1/32 (2^-PLAN_Q); rescaled to
    // the Q format with plan_const() so they track any FRAC.
    localparam int PLAN_Q       = 5;
    localparam int PLAN_X_SAT   = 160;  // 5.0
    localparam int PLAN_X_MID   = 76;   // 2.375
    localparam int PLAN_X_LO    = 32;   // 1.0
    localparam int PLAN_OFF_HI  = 27;   // 0.84375
    localparam int PLAN_OFF_MID = 20;   // 0.625
    localparam int PLAN_OFF_LO  = 16;   // 0.5

    function automatic int plan_const(input int c, input int frac);
        return (c << frac) >>> PLAN_Q;
    endfunction

    // Narrow a wide signed value to 'bits' bits, returned sign-extended.
    function automatic logic signed [FX_W-1:0] fx_narrow(
        input logic signed [FX_W-1:0] v,
        input int                     bits
    );
`ifdef NEURON_SAT_EN
        logic signed [FX_W-1:0] hi;
        logic signed [FX_W-1:0] lo;
        hi = (64'sd1 <<< (bits - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (bits - 1));
        if (v > hi)
            return hi;
        else if (v < lo)
            return lo;
        else
            return v;
`else
        return (v <<< (FX_W - bits)) >>> (FX_W - bits);
`endif
    endfunction

    // Q-format multiply: full product, arithmetic shift by frac, narrow.
    function automatic logic signed [FX_W-1:0] fx_mul(
        input logic signed [FX_W-1:0] a,
        input logic signed [FX_W-1:0] b,
        input int                     bits,
        input int                     frac
    );
        logic signed [FX_W-1:0] p;
        p = a * b;
        return fx_narrow(p >>> frac, bits);
    endfunction

endpackage

`default_nettype wire

// File: rtl/neuron_sigmoid_mac_if.sv
// ============================================================================
//  Module   : neuron_sigmoid_mac_if
//  Purpose  : Handshake and data bundle of neuron_sigmoid_mac. N and BITS
//             must match the parameters of the attached neuron.
//  Config   : none (NEURON_SAT_EN affects only the neuron datapath)
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

interface neuron_sigmoid_mac_if #(
    parameter int N    = 30,
    parameter int BITS = 16
);
    logic                     start_fp;
    logic                     start_bp;
    logic [N-1:0][BITS-1:0]   x;
    logic [N-1:0][BITS-1:0]   w;
    logic [BITS-1:0]          b;
    logic [BITS-1:0]          y_true;
    logic [BITS-1:0]          lr;
    logic                     busy;
    logic                     done;
    logic [BITS-1:0]          y;
    logic                     yhat;
    logic [BITS-1:0]          dz_out;
    logic [N-1:0][BITS-1:0]   w_out;
    logic [BITS-1:0]          b_out;

    modport master (
        output start_fp, start_bp, x, w, b, y_true, lr,
        input  busy, done, y, yhat, dz_out, w_out, b_out
    );

    modport slave (
        input  start_fp, start_bp, x, w, b, y_true, lr,
        output busy, done, y, yhat, dz_out, w_out, b_out
    );
endinterface

`default_nettype wire

// File: rtl/neuron_sigmoid_mac_sigmoid.sv
// ============================================================================
//  Module   : sigmoid_plan
//  Purpose  : Combinational piecewise-linear (PLAN) sigmoid on Q(BITS-FRAC).FRAC
//             evaluated on |z| and mirrored with f(-z) = 1 - f(z).
//  Config   : none
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module sigmoid_plan
    import neuron_pkg::*;
#(
    parameter int BITS = 16,
    parameter int FRAC = 8
) (
    input  wire logic [BITS-1:0] i_z,
    output logic      [BITS-1:0] o_y
);

    localparam logic [BITS-1:0] C_ONE     = BITS'(1 << FRAC);
    localparam logic [BITS-1:0] C_MAX     = {1'b0, {(BITS-1){1'b1}}};
    localparam logic [BITS-1:0] C_MIN     = {1'b1, {(BITS-1){1'b0}}};
    localparam logic [BITS-1:0] C_X_SAT   = BITS'(plan_const(PLAN_X_SAT,   FRAC));
    localparam logic [BITS-1:0] C_X_MID   = BITS'(plan_const(PLAN_X_MID,   FRAC));
    localparam logic [BITS-1:0] C_X_LO    = BITS'(plan_const(PLAN_X_LO,    FRAC));
    localparam logic [BITS-1:0] C_OFF_HI  = BITS'(plan_const(PLAN_OFF_HI,  FRAC));
    localparam logic [BITS-1:0] C_OFF_MID = BITS'(plan_const(PLAN_OFF_MID, FRAC));
    localparam logic [BITS-1:0] C_OFF_LO  = BITS'(plan_const(PLAN_OFF_LO,  FRAC));

    logic            w_neg;
    logic [BITS-1:0] w_abs;
    logic [BITS-1:0] w_f;

    // Magnitude, PLAN segment select (slopes 1/32, 1/8, 1/4 as shifts), mirror
    always_comb begin
        w_neg = i_z[BITS-1];
        // The most negative code has no positive twin; clamp it to max.
        if (i_z == C_MIN)
            w_abs = C_MAX;
        else if (w_neg)
            w_abs = -i_z;
        else
            w_abs = i_z;

        if (w_abs >= C_X_SAT)
            w_f = C_ONE;
        else if (w_abs >= C_X_MID)
            w_f = (w_abs >> 5) + C_OFF_HI;
        else if (w_abs >= C_X_LO)
            w_f = (w_abs >> 3) + C_OFF_MID;
        else
            w_f = (w_abs >> 2) + C_OFF_LO;

        o_y = w_neg ? (C_ONE - w_f) : w_f;
    end

endmodule

`default_nettype wire

// File: rtl/neuron_sigmoid_mac.sv
// ============================================================================
//  Module   : neuron_sigmoid_mac
//  Purpose  : Sigmoid output neuron with LANES-wide MAC forward pass and
//             gradient-descent backward pass, start/busy/done handshake.
//  Config   : NEURON_SAT_EN -> all narrowing saturates; otherwise wraps.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module neuron_sigmoid_mac
    import neuron_pkg::*;
#(
    parameter int N     = 30,
    parameter int BITS  = 16,
    parameter int FRAC  = 8,
    parameter int LANES = 2
) (
    input  wire logic              clk,
    input  wire logic              rst,
    neuron_sigmoid_mac_if.slave    bus
);

    localparam int M      = (N + LANES - 1) / LANES;
    localparam int ACC_W  = BITS + $clog2(N + 1);
    localparam int STEP_W = (M > 1) ? $clog2(M) : 1;

    state_t                        r_state;
    state_t                        w_state_next;
    logic                          w_accept_fp;
    logic                          w_accept_bp;
    logic                          w_last_step;
    logic [STEP_W-1:0]             r_step;

    // Operands captured at acceptance
    logic [N-1:0][BITS-1:0]        r_x;
    logic [N-1:0][BITS-1:0]        r_w;
    logic [BITS-1:0]               r_b;
    logic [BITS-1:0]               r_ytrue;
    logic [BITS-1:0]               r_lr;

    // Forward / backward state
    logic signed [ACC_W-1:0]       r_acc;
    logic signed [ACC_W-1:0]       w_acc_next;
    logic [BITS-1:0]               r_y;
    logic                          r_yhat;
    logic [BITS-1:0]               r_dz;
    logic [BITS-1:0]               r_g;
    logic [BITS-1:0]               r_b_out;
    logic [N-1:0][BITS-1:0]        r_w_out;

    // Operands zero-padded to M*LANES so tail lanes see x = w = 0
    logic [M-1:0][LANES-1:0][BITS-1:0] w_x_tab;
    logic [M-1:0][LANES-1:0][BITS-1:0] w_w_tab;
    logic [LANES-1:0][BITS-1:0]        w_prod;
    logic [LANES-1:0][BITS-1:0]        w_upd;

    logic [BITS-1:0]               w_z;
    logic [BITS-1:0]               w_sig;
    logic [BITS-1:0]               w_dz;
    logic [BITS-1:0]               w_g;
    logic [BITS-1:0]               w_b_new;

    assign w_x_tab     = (M*LANES*BITS)'(r_x);
    assign w_w_tab     = (M*LANES*BITS)'(r_w);
    assign w_last_step = (r_step == STEP_W'(M - 1));

    // State register
    always_ff @(posedge clk) begin
        if (rst)
            r_state <= IDLE;
        else
            r_state <= w_state_next;
    end

    // Next-state and acceptance decode; FP wins when both starts are high
    always_comb begin
        w_state_next = r_state;
        w_accept_fp  = 1'b0;
        w_accept_bp  = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.start_fp) begin
                    w_accept_fp  = 1'b1;
                    w_state_next = FP_MAC;
                end else if (bus.start_bp) begin
                    w_accept_bp  = 1'b1;
                    w_state_next = BP_DZ;
                end
            end
            FP_MAC:  if (w_last_step) w_state_next = FP_ACT;
            FP_ACT:  w_state_next = DONE;
            BP_DZ:   w_state_next = BP_G;
            BP_G:    w_state_next = BP_UPD;
            BP_UPD:  if (w_last_step) w_state_next = DONE;
            DONE:    w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // DONE is not counted as busy: the pass has finished in that cycle.
    assign bus.busy = (r_state != IDLE) && (r_state != DONE);
    assign bus.done = (r_state == DONE);

    // Lane step counter, idles at zero outside the multi-cycle states
    always_ff @(posedge clk) begin
        if (rst)
            r_step <= '0;
        else if ((r_state == FP_MAC || r_state == BP_UPD) && !w_last_step)
            r_step <= r_step + 1'b1;
        else
            r_step <= '0;
    end

    // Operand capture on acceptance; later input changes are ignored
    always_ff @(posedge clk) begin
        if (rst) begin
            r_x     <= '0;
            r_w     <= '0;
            r_b     <= '0;
            r_ytrue <= '0;
            r_lr    <= '0;
        end else if (w_accept_fp || w_accept_bp) begin
            r_x     <= bus.x;
            r_w     <= bus.w;
            r_b     <= bus.b;
            r_ytrue <= bus.y_true;
            r_lr    <= bus.lr;
        end
    end

    // Per-lane product (forward) and weight update (backward)
    for (genvar k = 0; k < LANES; k++) begin : g_lane
        logic [BITS-1:0] w_xl;
        logic [BITS-1:0] w_wl;
        logic [BITS-1:0] w_gx;

        assign w_xl      = w_x_tab[r_step][k];
        assign w_wl      = w_w_tab[r_step][k];
        assign w_prod[k] = BITS'(fx_mul(FX_W'($signed(w_xl)), FX_W'($signed(w_wl)), BITS, FRAC));
        assign w_gx      = BITS'(fx_mul(FX_W'($signed(r_g)), FX_W'($signed(w_xl)), BITS, FRAC));
        assign w_upd[k]  = BITS'(fx_narrow(FX_W'($signed(w_wl)) - FX_W'($signed(w_gx)), BITS));
    end

    // Accumulator plus this step's lane products
    always_comb begin
        w_acc_next = r_acc;
        for (int k = 0; k < LANES; k++)
            w_acc_next = w_acc_next + ACC_W'($signed(w_prod[k]));
    end

    assign w_z     = BITS'(fx_narrow(FX_W'(r_acc) + FX_W'($signed(r_b)), BITS));
    assign w_dz    = BITS'(fx_narrow(FX_W'($signed(r_y)) - FX_W'($signed(r_ytrue)), BITS));
    assign w_g     = BITS'(fx_mul(FX_W'($signed(r_lr)), FX_W'($signed(r_dz)), BITS, FRAC));
    assign w_b_new = BITS'(fx_narrow(FX_W'($signed(r_b)) - FX_W'($signed(w_g)), BITS));

    sigmoid_plan #(
        .BITS (BITS),
        .FRAC (FRAC)
    ) u_sigmoid (
        .i_z (w_z),
        .o_y (w_sig)
    );

    // Forward pass: accumulate over M steps, then form z and y
    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc  <= '0;
            r_y    <= '0;
            r_yhat <= 1'b0;
        end else begin
            if (w_accept_fp)
                r_acc <= '0;
            else if (r_state == FP_MAC)
                r_acc <= w_acc_next;
            if (r_state == FP_ACT) begin
                r_y    <= w_sig;
                r_yhat <= ~w_z[BITS-1];
            end
        end
    end

    // Backward pass: dz, then g and the new bias
    always_ff @(posedge clk) begin
        if (rst) begin
            r_dz    <= '0;
            r_g     <= '0;
            r_b_out <= '0;
        end else begin
            if (r_state == BP_DZ)
                r_dz <= w_dz;
            if (r_state == BP_G) begin
                r_g     <= w_g;
                r_b_out <= w_b_new;
            end
        end
    end

    // Each weight output register is written by its fixed lane on its step
    for (genvar i = 0; i < N; i++) begin : g_wout
        // Update weight i during BP_UPD step i/LANES
        always_ff @(posedge clk) begin
            if (rst)
                r_w_out[i] <= '0;
            else if (r_state == BP_UPD && r_step == STEP_W'(i / LANES))
                r_w_out[i] <= w_upd[i % LANES];
        end
    end

    assign bus.y      = r_y;
    assign bus.yhat   = r_yhat;
    assign bus.dz_out = r_dz;
    assign bus.w_out  = r_w_out;
    assign bus.b_out  = r_b_out;

endmodule

`default_nettype wire
